dct_scheduler: RTL and testbench
================================

Name: dct_scheduler

Overview:
- Sequences the per-coefficient DCT engine across whole images.
- For each 8x8 pixel block it requests the block's colours from upstream.
- It then walks all 64 (u,v) frequency pairs, pulses the engine's go, and waits for its finished flag.
- It writes each resulting Y/Cb/Cr coefficient triple to the coefficient memory. It sits between the block-gathering stage and the quantiser/entropy stage.

Parameters:
- q_full, 32, width of signed fixed-point coefficients.
- address_len, 12, width of the u/v ports driven to the DCT engine.
- block_len, 16, width of the block counter and num_blocks.
- timeout_cycles, 1023, max cycles to wait for the finished flag per coefficient.
- timeout_len, 10, width of the watchdog counter; must hold timeout_cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins processing num_blocks blocks.
- num_blocks  in  block_len  number of 8x8 blocks; sampled on accepted start.
- y_active_in  in  1  luma enable; sampled on accepted start.
- c_active_in  in  1  chroma enable; sampled on accepted start.
- block_req  out  1  request for the next block's group colours.
- block_ready  in  1  upstream acknowledge; group colours are valid and held stable until the next block_req.
- dct_go  out  1  go strobe to the DCT engine.
- dct_y_active  out  1  registered copy of y_active_in.
- dct_c_active  out  1  registered copy of c_active_in.
- dct_u  out  address_len  current u (0..7).
- dct_v  out  address_len  current v (0..7).
- dct_finished_flag  in  1  DCT engine completion flag.
- dct_y  in  q_full  signed Y coefficient from the engine.
- dct_cb  in  q_full  signed Cb coefficient from the engine.
- dct_cr  in  q_full  signed Cr coefficient from the engine.
- coef_w_en  out  1  coefficient write strobe.
- coef_w_addr  out  block_len+6  write address = block_idx*64 + u*8 + v.
- coef_w_y  out  q_full  Y coefficient write data.
- coef_w_cb  out  q_full  Cb coefficient write data.
- coef_w_cr  out  q_full  Cr coefficient write data.
- busy  out  1  high from accepted start until done or error.
- done  out  1  one-cycle pulse when all blocks are written.
- error  out  1  sticky watchdog timeout flag.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters (block_idx, u, v, watchdog) 0. Reset mid-run aborts at once. dct_go drops the same edge; no further coef_w_en.
- States: IDLE, FETCH, GO, ARM, WAIT, STORE, NEXT, FINISH.
- IDLE:
  - start with busy=0 → latch num_blocks and the active enables; set busy=1; clear error.
  - If num_blocks==0 → FINISH, else → FETCH.
  - start while busy=1 is ignored.
- FETCH: block_req=1 until block_ready is sampled high. Then block_req=0, u=v=0 → GO.
- GO: dct_go=1 for exactly one cycle, with dct_u/dct_v already stable since the previous cycle → ARM.
- ARM: dct_go=0; dct_finished_flag is not sampled (the engine clears it on go's rising edge); watchdog cleared → WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - dct_finished_flag=1 → capture dct_y/cb/cr into the write-data registers → STORE.
  - Watchdog reaches timeout_cycles with no flag → error=1, busy=0 → IDLE.
- STORE: coef_w_en=1 for one cycle with coef_w_addr = block_idx*64 + u*8 + v → NEXT.
- NEXT:
  - v increments. On v wrap 7→0, u increments. Order is v inner, u outer.
  - If u=7 and v=7 were just stored → block_idx+1. If block_idx+1 == num_blocks → FINISH, else → FETCH.
  - Otherwise → GO.
- FINISH: done=1 one cycle; busy=0 → IDLE.
- Inactive channels: the write data for a disabled channel is whatever the engine presents; it is written unmodified.
- Coefficient count: exactly 64 writes per block, addresses strictly increasing. Minimum per-coefficient overhead is 5 cycles beyond engine latency.
- Simultaneous start and reset: reset wins.
- block_ready outside FETCH: ignored.

Test Plan:
- num_blocks=1, y and c active, model engine finishing after 260 cycles returning y=u*8+v → 64 writes, addresses 0..63, coef_w_y equals the address; done pulses once; busy falls with done.
- num_blocks=3 → 192 writes, addresses 0..191 in order; block_req asserted 3 times; block_ready delayed 10 cycles on block 2 → no go until ready.
- num_blocks=0 start → done on the next cycle after FINISH; no block_req, dct_go or coef_w_en.
- Engine never finishes, timeout_cycles=1023 → error=1 after 1023 WAIT cycles, busy=0, no write. A new start clears error and the run completes normally.
- reset asserted during WAIT of coefficient 20 → next cycle all outputs 0; no further writes; restart begins at address 0.
- start pulsed again mid-run → ignored; write count and order unchanged.
- Stale finished flag held at 1 from the previous coefficient → no write until the flag re-asserts after ARM.

Source files
------------

// File: rtl/dct_scheduler_if.sv
// dct_scheduler_if: bundles every non-clock signal of the DCT scheduler.
//   Control   : start, num_blocks, y_active_in, c_active_in -> busy, done, error
//   Upstream  : block_req -> / <- block_ready
//   DCT engine: dct_go, dct_y_active, dct_c_active, dct_u, dct_v ->
//               <- dct_finished_flag, dct_y, dct_cb, dct_cr
//   Coef mem  : coef_w_en, coef_w_addr, coef_w_y, coef_w_cb, coef_w_cr
// Modports: master = the scheduler, slave = its environment.
interface dct_scheduler_if #(
  parameter int unsigned q_full      = 32,
  parameter int unsigned address_len = 12,
  parameter int unsigned block_len   = 16
);
  // run control
  logic                          start;
  logic [block_len-1:0]          num_blocks;
  logic                          y_active_in;
  logic                          c_active_in;
  logic                          busy;
  logic                          done;
  logic                          error;

  // upstream block handshake
  logic                          block_req;
  logic                          block_ready;

  // DCT engine
  logic                          dct_go;
  logic                          dct_y_active;
  logic                          dct_c_active;
  logic [address_len-1:0]        dct_u;
  logic [address_len-1:0]        dct_v;
  logic                          dct_finished_flag;
  logic signed [q_full-1:0]      dct_y;
  logic signed [q_full-1:0]      dct_cb;
  logic signed [q_full-1:0]      dct_cr;

  // coefficient memory write port
  logic                          coef_w_en;
  logic [block_len+5:0]          coef_w_addr;
  logic signed [q_full-1:0]      coef_w_y;
  logic signed [q_full-1:0]      coef_w_cb;
  logic signed [q_full-1:0]      coef_w_cr;

  modport master (
    input  start, num_blocks, y_active_in, c_active_in,
    output busy, done, error,
    output block_req,
    input  block_ready,
    output dct_go, dct_y_active, dct_c_active, dct_u, dct_v,
    input  dct_finished_flag, dct_y, dct_cb, dct_cr,
    output coef_w_en, coef_w_addr, coef_w_y, coef_w_cb, coef_w_cr
  );

  modport slave (
    output start, num_blocks, y_active_in, c_active_in,
    input  busy, done, error,
    input  block_req,
    output block_ready,
    input  dct_go, dct_y_active, dct_c_active, dct_u, dct_v,
    output dct_finished_flag, dct_y, dct_cb, dct_cr,
    input  coef_w_en, coef_w_addr, coef_w_y, coef_w_cb, coef_w_cr
  );
endinterface

// File: rtl/dct_scheduler.sv
// dct_scheduler: sequences the per-coefficient DCT engine over a whole image.
// For every 8x8 block it requests the block colours upstream, then walks the
// 64 (u,v) pairs (v inner, u outer), strobes the engine, waits for its
// finished flag under a watchdog and writes the Y/Cb/Cr triple to the
// coefficient memory at block_idx*64 + u*8 + v.
// Ports:
//   clk   - system clock, all logic on posedge
//   reset - synchronous active-high reset, aborts any run immediately
//   bus   - dct_scheduler_if.master (control, upstream, engine, coef memory)
module dct_scheduler #(
  parameter int unsigned q_full         = 32,
  parameter int unsigned address_len    = 12,
  parameter int unsigned block_len      = 16,
  parameter int unsigned timeout_cycles = 1023,
  parameter int unsigned timeout_len    = 10
) (
  input  logic           clk,
  input  logic           reset,
  dct_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    GO,
    ARM,
    WAIT,
    STORE,
    NEXT,
    FINISH
  } state_t;

  localparam logic [timeout_len-1:0] wd_last = timeout_len'(timeout_cycles - 1);

  state_t               state;
  logic [block_len-1:0] nblocks;
  logic [block_len-1:0] block_idx;
  logic [2:0]           u;
  logic [2:0]           v;
  logic [timeout_len-1:0] wd;

  // u/v are registers; the engine ports are just their zero-extension.
  always_comb begin
    bus.dct_u = address_len'(u);
    bus.dct_v = address_len'(v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      nblocks          <= '0;
      block_idx        <= '0;
      u                <= '0;
      v                <= '0;
      wd               <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.block_req    <= 1'b0;
      bus.dct_go       <= 1'b0;
      bus.dct_y_active <= 1'b0;
      bus.dct_c_active <= 1'b0;
      bus.coef_w_en    <= 1'b0;
      bus.coef_w_addr  <= '0;
      bus.coef_w_y     <= '0;
      bus.coef_w_cb    <= '0;
      bus.coef_w_cr    <= '0;
    end else begin
      // single-cycle strobes
      bus.dct_go    <= 1'b0;
      bus.coef_w_en <= 1'b0;
      bus.done      <= 1'b0;

      unique case (state)
        IDLE: begin
          // busy is always low here, so any start seen in IDLE is accepted
          if (bus.start) begin
            nblocks          <= bus.num_blocks;
            bus.dct_y_active <= bus.y_active_in;
            bus.dct_c_active <= bus.c_active_in;
            bus.busy         <= 1'b1;
            bus.error        <= 1'b0;
            block_idx        <= '0;
            u                <= '0;
            v                <= '0;
            if (bus.num_blocks == '0) begin
              state <= FINISH;
            end else begin
              bus.block_req <= 1'b1;
              state         <= FETCH;
            end
          end
        end

        FETCH: begin
          if (bus.block_ready) begin
            bus.block_req <= 1'b0;
            u             <= '0;
            v             <= '0;
            bus.dct_go    <= 1'b1;
            state         <= GO;
          end
        end

        // dct_go is raised on entry so it is high exactly while in GO;
        // u/v were settled one cycle earlier (in FETCH or NEXT).
        GO: begin
          state <= ARM;
        end

        // The engine drops its flag on go's rising edge; the flag value seen
        // here may still be the previous coefficient's, so it is ignored.
        ARM: begin
          wd    <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (bus.dct_finished_flag) begin
            bus.coef_w_y    <= q_full'(bus.dct_y);
            bus.coef_w_cb   <= q_full'(bus.dct_cb);
            bus.coef_w_cr   <= q_full'(bus.dct_cr);
            bus.coef_w_addr <= {block_idx, u, v};
            bus.coef_w_en   <= 1'b1;
            state           <= STORE;
          end else if (wd == wd_last) begin
            bus.error <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        // Advance the coefficient walk here so the new u/v are already on the
        // engine ports during NEXT, one cycle ahead of the next go.
        STORE: begin
          v <= v + 3'd1;
          if (v == 3'd7) begin
            u <= u + 3'd1;
          end
          if ((u == 3'd7) && (v == 3'd7)) begin
            block_idx <= block_idx + 1'b1;
          end
          state <= NEXT;
        end

        // u==v==0 after the advance means (7,7) was just stored and block_idx
        // already holds the incremented count.
        NEXT: begin
          if ((u == 3'd0) && (v == 3'd0)) begin
            if (block_idx == nblocks) begin
              state <= FINISH;
            end else begin
              bus.block_req <= 1'b1;
              state         <= FETCH;
            end
          end else begin
            bus.dct_go <= 1'b1;
            state      <= GO;
          end
        end

        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_scheduler.sv
// tb_dct_scheduler: randomized self-checking bench for dct_scheduler.
// A behavioural engine, an upstream block source and a monitor surround the
// DUT; expected writes are derived from the write index (addresses are simply
// sequential, coefficient data is a function of a per-run salt and u*8+v).
module tb_dct_scheduler;
  localparam int QF = 32;
  localparam int AL = 12;
  localparam int BL = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dct_scheduler_if #(.q_full(QF), .address_len(AL), .block_len(BL)) bus ();

  dct_scheduler #(
    .q_full(QF),
    .address_len(AL),
    .block_len(BL),
    .timeout_cycles(1023),
    .timeout_len(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // reference coefficient values
  function automatic logic [31:0] ref_y(input int s, input int uv);
    return 32'(s) ^ 32'(uv);
  endfunction
  function automatic logic [31:0] ref_cb(input int s, input int uv);
    return ~ref_y(s, uv) + 32'd1;
  endfunction
  function automatic logic [31:0] ref_cr(input int s, input int uv);
    return ref_y(s, uv) * 32'd5 + 32'd3;
  endfunction

  // shared configuration written by the main sequence
  int eng_lat = 4;
  bit eng_never = 1'b0;
  bit eng_stale = 1'b0;
  int eng_salt = 0;
  bit slow_block2 = 1'b0;
  int wr_base = 0;
  int breq_base = 0;
  bit cur_ya = 1'b0;
  bit cur_ca = 1'b0;

  // counters owned by the monitor / upstream model
  int cyc = 0;
  int wr_cnt = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  int last_go_cyc = 0;
  int breq_cnt = 0;
  logic prev_go = 1'b0;
  logic [AL-1:0] prev_u = '0;
  logic [AL-1:0] prev_v = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine: clears its flag when it sees go (or one edge later in stale mode),
  // then raises it with the new data eng_lat cycles after that.
  int eng_cnt = 0;
  int eng_uv = 0;
  bit stale_clr = 1'b0;
  always @(posedge clk) begin
    if (bus.dct_go) begin
      eng_cnt <= eng_lat;
      eng_uv  <= int'(bus.dct_u) * 8 + int'(bus.dct_v);
      if (eng_stale) stale_clr <= 1'b1;
      else bus.dct_finished_flag <= 1'b0;
    end else begin
      if (stale_clr) begin
        bus.dct_finished_flag <= 1'b0;
        stale_clr <= 1'b0;
      end
      if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1 && !eng_never) begin
          bus.dct_finished_flag <= 1'b1;
          bus.dct_y  <= ref_y(eng_salt, eng_uv);
          bus.dct_cb <= ref_cb(eng_salt, eng_uv);
          bus.dct_cr <= ref_cr(eng_salt, eng_uv);
        end
      end
    end
  end

  // Upstream: answers each request after a delay (10 cycles on the second
  // block when slow_block2 is set); toggles block_ready randomly otherwise.
  initial begin
    int age;
    int target;
    age = 0;
    target = 0;
    bus.block_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        age = 0;
        bus.block_ready = 1'b0;
      end else if (bus.block_req) begin
        if (age == 0) begin
          breq_cnt++;
          target = (slow_block2 && (breq_cnt - breq_base == 2)) ? 10 : $urandom_range(0, 2);
        end
        bus.block_ready = (age >= target);
        age++;
      end else begin
        if (age > 0) check("req_len", age, target + 1);
        age = 0;
        bus.block_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: every go and every write is checked against the write index.
  always @(negedge clk) begin
    int k;
    if (!reset) begin
      if (bus.dct_go) begin
        k = (wr_cnt - wr_base) % 64;
        check("go_while_req", bus.block_req, 0);
        check("go_single", prev_go, 0);
        check("go_u_stable", bus.dct_u, prev_u);
        check("go_v_stable", bus.dct_v, prev_v);
        check("go_u", bus.dct_u, k / 8);
        check("go_v", bus.dct_v, k % 8);
        check("go_y_active", bus.dct_y_active, cur_ya);
        check("go_c_active", bus.dct_c_active, cur_ca);
        go_cnt <= go_cnt + 1;
        last_go_cyc <= cyc;
      end
      if (bus.coef_w_en) begin
        k = wr_cnt - wr_base;
        check("w_addr", bus.coef_w_addr, k);
        check("w_y", $unsigned(bus.coef_w_y), ref_y(eng_salt, k % 64));
        check("w_cb", $unsigned(bus.coef_w_cb), ref_cb(eng_salt, k % 64));
        check("w_cr", $unsigned(bus.coef_w_cr), ref_cr(eng_salt, k % 64));
        check("w_latency", cyc - last_go_cyc, eng_lat + 2);
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
    end
    prev_go <= bus.dct_go;
    prev_u  <= bus.dct_u;
    prev_v  <= bus.dct_v;
  end

  task automatic check_outputs_zero();
    check("z_block_req", bus.block_req, 0);
    check("z_dct_go", bus.dct_go, 0);
    check("z_y_active", bus.dct_y_active, 0);
    check("z_c_active", bus.dct_c_active, 0);
    check("z_u", bus.dct_u, 0);
    check("z_v", bus.dct_v, 0);
    check("z_w_en", bus.coef_w_en, 0);
    check("z_w_addr", bus.coef_w_addr, 0);
    check("z_w_y", $unsigned(bus.coef_w_y), 0);
    check("z_w_cb", $unsigned(bus.coef_w_cb), 0);
    check("z_w_cr", $unsigned(bus.coef_w_cr), 0);
    check("z_busy", bus.busy, 0);
    check("z_done", bus.done, 0);
    check("z_error", bus.error, 0);
  endtask

  // Drives one start pulse at a negedge; the DUT accepts it on the next edge.
  task automatic start_run(input int n, input bit ya, input bit ca);
    wr_base = wr_cnt;
    breq_base = breq_cnt;
    cur_ya = ya;
    cur_ca = ca;
    bus.num_blocks = 16'(n);
    bus.y_active_in = ya;
    bus.c_active_in = ca;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.num_blocks = 16'($urandom);
    bus.y_active_in = ~ya;
    bus.c_active_in = ~ca;
    check("start_busy", bus.busy, 1);
    check("start_error_clr", bus.error, 0);
    check("start_y_latch", bus.dct_y_active, ya);
    check("start_c_latch", bus.dct_c_active, ca);
  endtask

  task automatic run_blocks(input int n, input bit ya, input bit ca, input int lat,
                            input bit stale, input int salt, input bit mid_start,
                            input bit slow2);
    int w0, d0, g0, budget, done_i;
    bit seen;
    eng_lat = lat;
    eng_stale = stale;
    eng_salt = salt;
    eng_never = 1'b0;
    slow_block2 = slow2;
    @(negedge clk);
    w0 = wr_cnt;
    d0 = done_cnt;
    g0 = go_cnt;
    start_run(n, ya, ca);
    budget = n * 64 * (lat + 8) + 200;
    seen = 1'b0;
    done_i = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        done_i = i;
        check("busy_falls_with_done", bus.busy, 0);
      end else begin
        bus.start = mid_start && (i == 150);
        if (mid_start && i == 150) bus.num_blocks = 16'd7;
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    check("done_seen", seen, 1);
    if (n == 0) check("zero_done_delay", done_i, 1);
    @(negedge clk);
    check("done_single", bus.done, 0);
    check("done_count", done_cnt - d0, 1);
    check("write_count", wr_cnt - w0, n * 64);
    check("go_count", go_cnt - g0, n * 64);
    check("block_req_count", breq_cnt - breq_base, n);
    check("busy_idle", bus.busy, 0);
  endtask

  initial begin
    int w0, d0, g0, err_i;
    bit seen;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_blocks = '0;
    bus.y_active_in = 1'b0;
    bus.c_active_in = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero();
    reset = 1'b0;

    // single block, slow engine, y = u*8+v = address
    run_blocks(1, 1'b1, 1'b1, 260, 1'b0, 0, 1'b0, 1'b0);
    // three blocks, second block's ready delayed 10 cycles
    run_blocks(3, 1'b1, 1'b1, $urandom_range(2, 10), 1'b0, int'($urandom), 1'b0, 1'b1);
    // zero blocks
    run_blocks(0, 1'b1, 1'b0, 4, 1'b0, 0, 1'b0, 1'b0);

    // engine never finishes: watchdog error after 1023 WAIT cycles
    eng_never = 1'b1;
    eng_stale = 1'b0;
    eng_lat = 5;
    @(negedge clk);
    w0 = wr_cnt;
    d0 = done_cnt;
    start_run(1, 1'b1, 1'b1);
    seen = 1'b0;
    err_i = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (bus.error) begin
        seen = 1'b1;
        err_i = cyc - last_go_cyc;
      end
    end
    check("timeout_seen", seen, 1);
    check("timeout_delay", err_i, 1025);
    check("timeout_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    check("timeout_sticky", bus.error, 1);
    check("timeout_no_write", wr_cnt - w0, 0);
    check("timeout_no_done", done_cnt - d0, 0);
    // a new start clears error and completes normally
    run_blocks(1, 1'b0, 1'b1, $urandom_range(2, 6), 1'b0, int'($urandom), 1'b0, 1'b0);

    // reset during WAIT of coefficient 20
    eng_lat = 10;
    eng_never = 1'b0;
    @(negedge clk);
    g0 = go_cnt;
    w0 = wr_cnt;
    start_run(2, 1'b1, 1'b1);
    for (int i = 0; i < 4000 && (go_cnt - g0) < 21; i++) @(negedge clk);
    check("reach_coef20", go_cnt - g0, 21);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero();
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("reset_writes_stop", wr_cnt - w0, 20);
    run_blocks(1, 1'b1, 1'b1, $urandom_range(2, 6), 1'b0, int'($urandom), 1'b0, 1'b0);

    // start pulsed mid-run is ignored
    run_blocks(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(2, 8),
               1'b0, int'($urandom), 1'b1, 1'b0);
    // stale finished flag held through ARM
    run_blocks(1, 1'b1, 1'b1, $urandom_range(2, 6), 1'b1, int'($urandom), 1'b0, 1'b0);
    // random mix
    for (int r = 0; r < 3; r++) begin
      run_blocks($urandom_range(1, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(2, 8), 1'($urandom_range(0, 1)), int'($urandom), 1'b0,
                 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL global_timeout got=%0d expected=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
